backend_cfg_ctrl: RTL and testbench
===================================

# backend_cfg_ctrl

Configuration controller for the analog backend: arbitrates gain-update requests from two requesters and owns the backend's reset and serial-configuration lines. For each accepted request it resets the backend, shifts the 5-bit gain word onto the serial pins and waits for the backend's ready flag. Sits between the digital control logic and the backend, and is the only driver of the backend's `resetbAll`, `sclk` and `sdin`.

## Interface
- `SCLK_DIV`, default 2: i_clk cycles per o_sclk half-period (≥1).
- `RST_CYCLES`, default 4: i_clk cycles o_resetb_be is held low per transaction (≥1).
- `TIMEOUT`, default 64: i_clk cycles allowed for i_ready after frame end.
- `i_clk` in 1: the only clock; all logic on its rising edge.
- `i_resetbAll` in 1: reset, synchronous and active-low.
- `i_req` in 2: level request per requester; held until the matching o_gnt.
- `i_cfg0`, `i_cfg1` in 5 each: gain word {gainA2[2:0], gainA1[1:0]} for requester 0 and 1.
- `i_ready` in 1: backend ready flag.
- `o_gnt` out 2: one-hot, 1-cycle pulse; the request is accepted and its cfg is captured.
- `o_done` out 2: one-hot, 1-cycle pulse; the granted transaction has ended.
- `o_err` out 1: 1-cycle pulse, coincident with o_done, on timeout.
- `o_busy` out 1: high from the grant cycle through the done cycle.
- `o_resetb_be` out 1: backend reset, active-low.
- `o_sclk`, `o_sdin` out 1 each: serial config clock and data to the backend.

## Operation
- States: IDLE → RST → SHIFT → WAIT_RDY → DONE → IDLE.
- IDLE:
  - Samples i_req.
  - If any bit is set: grant it, capture that requester's cfg into a 5-bit shadow register, pulse o_gnt and go to RST.
  - Round-robin: if both are requesting, grant the requester not granted last. After reset, requester 0 wins.
- RST: o_resetb_be = 0 for RST_CYCLES cycles, then 1 on entry to SHIFT.
- SHIFT:
  - 5 bits, LSB first (shadow[0] first).
  - Each bit: low phase of SCLK_DIV cycles with o_sdin = bit, then high phase of SCLK_DIV cycles.
  - o_sdin is stable across each rising o_sclk edge.
  - Ends with o_sclk = 0 and o_sdin = 0.
- WAIT_RDY:
  - Watchdog counts from 0.
  - i_ready = 1 → DONE, ok.
  - Count reaches TIMEOUT-1 without i_ready → DONE, error.
- DONE:
  - Pulse o_done for the granted requester, plus o_err if error.
  - On error, o_resetb_be returns to 0 in this cycle and stays 0.
  - On success, o_resetb_be stays 1 until the next transaction's RST.
  - Next state is IDLE.
- Boundaries:
  - i_req held after o_gnt is ignored until IDLE.
  - A request still asserted in IDLE after DONE produces a new transaction.
  - i_ready high during RST or SHIFT is ignored.
  - i_ready already high on WAIT_RDY entry → DONE after 1 cycle.
  - Requests arriving during a transaction wait; none are dropped while held.

## Timing
- Reset values (i_resetbAll = 0 at a rising edge):
  - o_gnt = 0, o_done = 0, o_err = 0, o_busy = 0.
  - o_resetb_be = 0, o_sclk = 0, o_sdin = 0.
  - State IDLE, round-robin pointer = requester 0.
- Reset mid-transaction: everything takes reset values at that edge. No o_done for the aborted transaction.
- Cycle-level sequence, with i_req seen at edge N in IDLE:
  - Cycle N+1: o_gnt and o_busy high; o_resetb_be low for cycles N+1 … N+RST_CYCLES.
  - Cycle N+RST_CYCLES+1: o_resetb_be high, SHIFT starts.
  - SHIFT lasts 10·SCLK_DIV cycles.
  - Error path: o_done arrives TIMEOUT cycles after WAIT_RDY entry.
  - Success path: o_done is the cycle after i_ready is sampled high.
- Minimum transaction: RST_CYCLES + 10·SCLK_DIV + 2 cycles from grant to done. With defaults: 4 + 20 + 2 = 26.
- Counter widths: $clog2 of each parameter +1; no wrap within a state.

## Configuration
- `BECTRL_TIMEOUT_EN`:
  - Defined: the WAIT_RDY watchdog and o_err are as above.
  - Undefined: the watchdog is removed, WAIT_RDY waits indefinitely for i_ready, o_err is tied 0 and TIMEOUT is unused.

## Test plan
- Reset, then a single request with defaults:
  - Stimulus: i_req = 01, i_cfg0 = 5'b10110.
  - Required: o_gnt = 01; o_resetb_be low 4 cycles; o_sdin sampled at the 5 o_sclk rising edges reads 0,1,1,0,1.
  - Then i_ready driven high 3 cycles later gives o_done = 01, o_err = 0, o_resetb_be = 1.
- Both requesting from reset:
  - Stimulus: i_req = 11, held.
  - Required: grants alternate 01, 10, 01.
  - Each transaction uses its own cfg: i_cfg0 = 5'h03, i_cfg1 = 5'h1C serialized correctly.
- Timeout (macro defined, TIMEOUT = 64, i_ready held 0):
  - Required: o_done and o_err pulse exactly 64 cycles after WAIT_RDY entry.
  - o_resetb_be = 0 afterwards.
- Macro undefined:
  - Stimulus: i_ready held 0 for 500 cycles.
  - Required: o_busy stays 1 and o_err stays 0.
  - Raising i_ready gives o_done.
- Reset mid-SHIFT:
  - Stimulus: i_resetbAll low during the 3rd bit.
  - Required: all outputs zero at that edge and no o_done.
  - A pending i_req afterwards restarts from RST with requester 0 priority.
- SCLK_DIV = 1:
  - Required: o_sclk toggles every cycle and the frame occupies 10 cycles.

Source files
------------

// File: rtl/backend_cfg_ctrl.sv
// -----------------------------------------------------------------------------
// backend_cfg_ctrl
//
// Configuration controller for the analog backend. Two requesters compete for
// gain updates. A round-robin arbiter picks one. For each accepted request the
// block then:
//   1. captures the 5-bit gain word into a shadow register,
//   2. holds the backend in reset,
//   3. shifts the word out LSB first on sclk/sdin,
//   4. waits for the backend ready flag.
// This block is the only driver of the backend's reset and serial-config pins.
//
// Optional feature macro: BECTRL_TIMEOUT_EN
//   defined   -> a watchdog bounds WAIT_RDY. On expiry o_err pulses and the
//                backend is left in reset.
//   undefined -> WAIT_RDY waits for i_ready indefinitely and o_err stays 0.
//
// Parameters
//   SCLK_DIV    i_clk cycles per o_sclk half-period (>=1)
//   RST_CYCLES  i_clk cycles o_resetb_be is held low per transaction (>=1)
//   TIMEOUT     i_clk cycles allowed for i_ready after the frame ends
//
// Ports
//   i_clk        rising-edge clock
//   i_resetbAll  synchronous active-low reset
//   i_req[1:0]   level request per requester, held until its grant
//   i_cfg0/1     gain word {gainA2[2:0], gainA1[1:0]} of requester 0/1
//   i_ready      backend ready flag
//   o_gnt[1:0]   one-hot 1-cycle grant pulse (cfg captured)
//   o_done[1:0]  one-hot 1-cycle pulse when the granted transaction ends
//   o_err        1-cycle timeout pulse, coincident with o_done
//   o_busy       high from the grant cycle through the done cycle
//   o_resetb_be  backend reset, active-low
//   o_sclk       serial config clock
//   o_sdin       serial config data
// -----------------------------------------------------------------------------
module backend_cfg_ctrl #(
  parameter int SCLK_DIV   = 2,
  parameter int RST_CYCLES = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic       i_clk,
  input  logic       i_resetbAll,
  input  logic [1:0] i_req,
  input  logic [4:0] i_cfg0,
  input  logic [4:0] i_cfg1,
  input  logic       i_ready,
  output logic [1:0] o_gnt,
  output logic [1:0] o_done,
  output logic       o_err,
  output logic       o_busy,
  output logic       o_resetb_be,
  output logic       o_sclk,
  output logic       o_sdin
);

  // One shared counter serves RST, SHIFT and WAIT_RDY.
  // It is sized for the largest of the three limits.
  localparam int SW  = $clog2(SCLK_DIV) + 1;
  localparam int RW  = $clog2(RST_CYCLES) + 1;
  localparam int TW  = $clog2(TIMEOUT) + 1;
  localparam int CW0 = (SW > RW) ? SW : RW;
  localparam int CW  = (CW0 > TW) ? CW0 : TW;

  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(SCLK_DIV - 1);
`ifdef BECTRL_TIMEOUT_EN
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_SHIFT,
    S_WAIT,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    phase_q, phase_d;   // 10 half-periods: even = low, odd = high
  logic [3:0]    phase_nxt;
  logic [4:0]    shadow_q, shadow_d;
  logic          owner_q, owner_d;   // requester being served
  logic          prio_q, prio_d;     // requester that wins a tie
  logic          pick;
  logic [1:0]    gnt_q, gnt_d;
  logic [1:0]    done_q, done_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic          resetb_q, resetb_d;
  logic          sclk_q, sclk_d;
  logic          sdin_q, sdin_d;

  // A single requester wins outright.
  // On a tie, the requester not served last wins.
  assign pick      = (i_req == 2'b11) ? prio_q : i_req[1];
  assign phase_nxt = phase_q + 4'd1;

  // NOTE: every signal written below gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    shadow_d = shadow_q;
    owner_d  = owner_q;
    prio_d   = prio_q;
    gnt_d    = 2'b00;
    done_d   = 2'b00;
    err_d    = 1'b0;
    busy_d   = busy_q;
    resetb_d = resetb_q;
    sclk_d   = sclk_q;
    sdin_d   = sdin_q;

    unique case (state_q)
      S_IDLE: begin
        if (|i_req) begin
          owner_d  = pick;
          prio_d   = ~pick;
          shadow_d = pick ? i_cfg1 : i_cfg0;
          gnt_d    = pick ? 2'b10 : 2'b01;
          busy_d   = 1'b1;
          resetb_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_RST;
        end
      end

      S_RST: begin
        if (cnt_q == RST_LAST) begin
          resetb_d = 1'b1;
          cnt_d    = '0;
          phase_d  = 4'd0;
          sclk_d   = 1'b0;
          sdin_d   = shadow_q[0];
          state_d  = S_SHIFT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (phase_q == 4'd9) begin
            sclk_d  = 1'b0;
            sdin_d  = 1'b0;
            state_d = S_WAIT;
          end else begin
            phase_d = phase_nxt;
            sclk_d  = ~sclk_q;
            // Data changes only when a high phase ends.
            // This keeps sdin stable across every rising sclk.
            if (sclk_q) sdin_d = shadow_q[phase_nxt[3:1]];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_WAIT: begin
        if (i_ready) begin
          done_d  = owner_q ? 2'b10 : 2'b01;
          state_d = S_DONE;
        end
`ifdef BECTRL_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          done_d   = owner_q ? 2'b10 : 2'b01;
          err_d    = 1'b1;
          resetb_d = 1'b0;    // backend is left in reset after a timeout
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples its next value from the same pre-edge snapshot.
  always_ff @(posedge i_clk) begin
    if (!i_resetbAll) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      phase_q  <= 4'd0;
      // NOTE: the shadow word needs no reset for correctness.
      // It is cleared anyway so the block never shifts out X after reset.
      shadow_q <= 5'd0;
      owner_q  <= 1'b0;
      prio_q   <= 1'b0;
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      resetb_q <= 1'b0;
      sclk_q   <= 1'b0;
      sdin_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      shadow_q <= shadow_d;
      owner_q  <= owner_d;
      prio_q   <= prio_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      resetb_q <= resetb_d;
      sclk_q   <= sclk_d;
      sdin_q   <= sdin_d;
    end
  end

  assign o_gnt       = gnt_q;
  assign o_done      = done_q;
  assign o_err       = err_q;
  assign o_busy      = busy_q;
  assign o_resetb_be = resetb_q;
  assign o_sclk      = sclk_q;
  assign o_sdin      = sdin_q;

endmodule

// File: tb/tb_backend_cfg_ctrl.sv
// -----------------------------------------------------------------------------
// tb_backend_cfg_ctrl
//
// The bench instantiates two controllers:
//   dut_a  default parameters
//   dut_b  SCLK_DIV=1, RST_CYCLES=2, TIMEOUT=8
// A select signal routes stimulus to one of them at a time and muxes its
// outputs onto shared o_* nets.
//
// The expected grant order comes from a small round-robin model, kept as one
// "last served" index per controller.
// Serial frames are decoded from the pins. Each frame is compared against the
// gain word that was on the winning requester's cfg input when the grant was
// issued.
// -----------------------------------------------------------------------------
module tb_backend_cfg_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       sel;
  logic [1:0] req;
  logic [4:0] cfg0, cfg1;
  logic       ready;

  logic [1:0] req_a, req_b;
  logic       ready_a, ready_b;
  logic [1:0] gnt_a, gnt_b, done_a, done_b;
  logic       err_a, err_b, busy_a, busy_b, rbe_a, rbe_b;
  logic       sclk_a, sclk_b, sdin_a, sdin_b;

  logic [1:0] o_gnt, o_done;
  logic       o_err, o_busy, o_resetb_be, o_sclk, o_sdin;

  int errors = 0;
  int checks = 0;
  int last_rr [2];   // last requester served per controller, -1 = none

  always #5 clk = ~clk;

  assign req_a   = sel ? 2'b00 : req;
  assign req_b   = sel ? req : 2'b00;
  assign ready_a = sel ? 1'b0 : ready;
  assign ready_b = sel ? ready : 1'b0;

  assign o_gnt       = sel ? gnt_b  : gnt_a;
  assign o_done      = sel ? done_b : done_a;
  assign o_err       = sel ? err_b  : err_a;
  assign o_busy      = sel ? busy_b : busy_a;
  assign o_resetb_be = sel ? rbe_b  : rbe_a;
  assign o_sclk      = sel ? sclk_b : sclk_a;
  assign o_sdin      = sel ? sdin_b : sdin_a;

  backend_cfg_ctrl dut_a (
    .i_clk(clk), .i_resetbAll(rstn), .i_req(req_a), .i_cfg0(cfg0), .i_cfg1(cfg1),
    .i_ready(ready_a), .o_gnt(gnt_a), .o_done(done_a), .o_err(err_a),
    .o_busy(busy_a), .o_resetb_be(rbe_a), .o_sclk(sclk_a), .o_sdin(sdin_a)
  );

  backend_cfg_ctrl #(.SCLK_DIV(1), .RST_CYCLES(2), .TIMEOUT(8)) dut_b (
    .i_clk(clk), .i_resetbAll(rstn), .i_req(req_b), .i_cfg0(cfg0), .i_cfg1(cfg1),
    .i_ready(ready_b), .o_gnt(gnt_b), .o_done(done_b), .o_err(err_b),
    .o_busy(busy_b), .o_resetb_be(rbe_b), .o_sclk(sclk_b), .o_sdin(sdin_b)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  // Round-robin rule: a lone requester wins; on a tie, the one not served last.
  function automatic logic [1:0] predict(input logic [1:0] r, input int s);
    int w;
    if (r == 2'b01)      w = 0;
    else if (r == 2'b10) w = 1;
    else                 w = (last_rr[s] == 0) ? 1 : 0;
    last_rr[s] = w;
    return (w == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic apply_reset();
    rstn  = 1'b0;
    req   = 2'b00;
    ready = 1'b0;
    tick();
    tick();
    rstn  = 1'b1;
    last_rr[0] = -1;
    last_rr[1] = -1;
  endtask

  // Follows one transaction from grant to the idle cycle after done.
  //   mode 0: raise i_ready rdy_delay cycles after WAIT_RDY entry
  //   mode 1: keep i_ready low and expect a timeout after t cycles
  //   mode 2: keep i_ready low for 500 cycles, then raise it
  task automatic do_txn(input logic [1:0] exp_gnt, input logic [4:0] exp_cfg,
                        input logic [1:0] next_req, input bit scramble,
                        input int d, input int r, input int t,
                        input int mode, input int rdy_delay, input bit early);
    int n, lowcnt, nb, bad;
    logic [4:0] bits;
    logic prev_sclk, prev_sdin;

    n = 0;
    do begin
      tick();
      n++;
    end while (o_gnt === 2'b00 && n < 100);
    checks++;
    if (o_gnt !== exp_gnt) begin
      errors++;
      $display("FAIL gnt: got %b expected %b", o_gnt, exp_gnt);
      if (o_gnt === 2'b00) return;
    end
    checks++;
    if (o_busy !== 1'b1 || o_resetb_be !== 1'b0 || o_done !== 2'b00) begin
      errors++;
      $display("FAIL grant_cycle: busy=%b resetb=%b done=%b expected 1 0 00",
               o_busy, o_resetb_be, o_done);
    end

    req = next_req;
    if (scramble) begin
      cfg0 = 5'($urandom);
      cfg1 = 5'($urandom);
    end
    if (early) ready = 1'b1;

    lowcnt = 1;
    tick();
    checks++;
    if (o_gnt !== 2'b00) begin
      errors++;
      $display("FAIL gnt_pulse: got %b expected 00", o_gnt);
    end
    while (o_resetb_be === 1'b0 && lowcnt < 200) begin
      lowcnt++;
      tick();
    end
    checks++;
    if (lowcnt != r) begin
      errors++;
      $display("FAIL reset_len: got %0d expected %0d", lowcnt, r);
    end

    // Decode the frame: expected sclk level per cycle, sdin at rising edges.
    bad = 0;
    nb = 0;
    bits = 5'd0;
    prev_sclk = 1'b0;
    prev_sdin = o_sdin;
    for (int c = 0; c < 10 * d; c++) begin
      if (o_sclk !== 1'((c / d) % 2) || o_resetb_be !== 1'b1 || o_done !== 2'b00) bad++;
      if (o_sclk === 1'b1 && prev_sclk === 1'b0) begin
        if (o_sdin !== prev_sdin) bad++;
        if (nb < 5) bits[nb] = o_sdin;
        nb++;
      end
      prev_sclk = o_sclk;
      prev_sdin = o_sdin;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL sclk_pattern: got %0d bad cycles expected 0", bad);
    end
    checks++;
    if (nb != 5 || bits !== exp_cfg) begin
      errors++;
      $display("FAIL frame: got %0d bits value %b expected 5 bits value %b", nb, bits, exp_cfg);
    end
    checks++;
    if (o_sclk !== 1'b0 || o_sdin !== 1'b0) begin
      errors++;
      $display("FAIL frame_end: sclk=%b sdin=%b expected 0 0", o_sclk, o_sdin);
    end

    if (mode == 1) begin
      n = 0;
      while (o_done === 2'b00 && n < t + 50) begin
        tick();
        n++;
      end
      checks++;
      if (n != t || o_done !== exp_gnt || o_err !== 1'b1 || o_resetb_be !== 1'b0) begin
        errors++;
        $display("FAIL timeout: cycles=%0d done=%b err=%b resetb=%b expected %0d %b 1 0",
                 n, o_done, o_err, o_resetb_be, t, exp_gnt);
      end
    end else begin
      bad = 0;
      n = (mode == 2) ? 500 : rdy_delay;
      for (int k = 0; k < n; k++) begin
        if (o_done !== 2'b00 || o_err !== 1'b0 || o_busy !== 1'b1) bad++;
        tick();
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL wait_hold: got %0d bad cycles expected 0", bad);
      end
      ready = 1'b1;
      tick();
      ready = 1'b0;
      checks++;
      if (o_done !== exp_gnt || o_err !== 1'b0 || o_resetb_be !== 1'b1 || o_busy !== 1'b1) begin
        errors++;
        $display("FAIL done: done=%b err=%b resetb=%b busy=%b expected %b 0 1 1",
                 o_done, o_err, o_resetb_be, o_busy, exp_gnt);
      end
    end

    tick();
    checks++;
    if (o_busy !== 1'b0 || o_done !== 2'b00 || o_err !== 1'b0 ||
        o_resetb_be !== ((mode == 1) ? 1'b0 : 1'b1)) begin
      errors++;
      $display("FAIL after_done: busy=%b done=%b err=%b resetb=%b", o_busy, o_done,
               o_err, o_resetb_be);
    end
  endtask

  task automatic test_reset();
    sel = 1'b0;
    cfg0 = 5'd0;
    cfg1 = 5'd0;
    apply_reset();
    rstn = 1'b0;
    tick();
    checks++;
    if ({gnt_a, done_a, err_a, busy_a, rbe_a, sclk_a, sdin_a,
         gnt_b, done_b, err_b, busy_b, rbe_b, sclk_b, sdin_b} !== 22'd0) begin
      errors++;
      $display("FAIL reset_values: a=%b%b%b%b%b%b%b b=%b%b%b%b%b%b%b expected all 0",
               gnt_a, done_a, err_a, busy_a, rbe_a, sclk_a, sdin_a,
               gnt_b, done_b, err_b, busy_b, rbe_b, sclk_b, sdin_b);
    end
    rstn = 1'b1;
  endtask

  task automatic test_single();
    sel  = 1'b0;
    cfg0 = 5'b10110;
    req  = 2'b01;
    do_txn(predict(2'b01, 0), 5'b10110, 2'b00, 1'b1, 2, 4, 64, 0, 3, 1'b0);
  endtask

  task automatic test_round_robin();
    logic [1:0] g;
    apply_reset();
    sel  = 1'b0;
    cfg0 = 5'h03;
    cfg1 = 5'h1C;
    req  = 2'b11;
    for (int i = 0; i < 3; i++) begin
      g = predict(2'b11, 0);
      do_txn(g, (g == 2'b01) ? 5'h03 : 5'h1C, (i == 2) ? 2'b00 : 2'b11, 1'b0,
             2, 4, 64, 0, 1, 1'b0);
    end
  endtask

  task automatic test_ready_early();
    sel  = 1'b0;
    cfg1 = 5'($urandom);
    req  = 2'b10;
    do_txn(predict(2'b10, 0), cfg1, 2'b00, 1'b1, 2, 4, 64, 0, 0, 1'b1);
  endtask

  task automatic test_random();
    logic [1:0] held, r, g, nxt;
    held = 2'b00;
    sel = 1'b0;
    for (int i = 0; i < 20; i++) begin
      r = held | 2'($urandom_range(0, 3));
      if (r == 2'b00) r = 2'($urandom_range(1, 3));
      cfg0 = 5'($urandom);
      cfg1 = 5'($urandom);
      req  = r;
      g    = predict(r, 0);
      // The loser of a tie keeps requesting.
      // A new requester may also arrive mid-transaction.
      nxt  = (r & ~g) | 2'($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0);
      held = nxt;
      do_txn(g, (g == 2'b01) ? cfg0 : cfg1, nxt, 1'b1, 2, 4, 64, 0,
             $urandom_range(0, 6), 1'b0);
    end
    req = 2'b00;
  endtask

`ifdef BECTRL_TIMEOUT_EN
  task automatic test_timeout();
    sel  = 1'b0;
    cfg0 = 5'($urandom);
    req  = 2'b01;
    do_txn(predict(2'b01, 0), cfg0, 2'b00, 1'b1, 2, 4, 64, 1, 0, 1'b0);
    cfg1 = 5'($urandom);
    req  = 2'b10;
    do_txn(predict(2'b10, 0), cfg1, 2'b00, 1'b1, 2, 4, 64, 0, 2, 1'b0);
  endtask
`else
  task automatic test_no_timeout();
    sel  = 1'b0;
    cfg0 = 5'($urandom);
    req  = 2'b01;
    do_txn(predict(2'b01, 0), cfg0, 2'b00, 1'b1, 2, 4, 64, 2, 0, 1'b0);
  endtask
`endif

  task automatic test_reset_mid_shift();
    int n;
    sel  = 1'b0;
    cfg0 = 5'b11111;
    req  = 2'b10;
    n = 0;
    do begin
      tick();
      n++;
    end while (o_gnt === 2'b00 && n < 100);
    req = 2'b11;
    // 4 reset cycles to the first SHIFT cycle, then 9 more into bit 2.
    repeat (4 + 9) tick();
    rstn = 1'b0;
    tick();
    checks++;
    if ({o_gnt, o_done, o_err, o_busy, o_resetb_be, o_sclk, o_sdin} !== 9'd0) begin
      errors++;
      $display("FAIL mid_reset: got %b expected all 0",
               {o_gnt, o_done, o_err, o_busy, o_resetb_be, o_sclk, o_sdin});
    end
    rstn = 1'b1;
    last_rr[0] = -1;
    last_rr[1] = -1;
    cfg0 = 5'h0A;
    cfg1 = 5'h15;
    do_txn(predict(2'b11, 0), 5'h0A, 2'b00, 1'b1, 2, 4, 64, 0, 1, 1'b0);
  endtask

  task automatic test_fast();
    logic [1:0] g;
    sel = 1'b1;
    tick();
    cfg1 = 5'($urandom);
    req  = 2'b10;
    do_txn(predict(2'b10, 1), cfg1, 2'b00, 1'b1, 1, 2, 8, 0, 1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cfg0 = 5'($urandom);
      cfg1 = 5'($urandom);
      req  = 2'b11;
      g = predict(2'b11, 1);
      do_txn(g, (g == 2'b01) ? cfg0 : cfg1, 2'b00, 1'b1, 1, 2, 8, 0, 0, 1'b0);
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_ready_early();
    test_random();
`ifdef BECTRL_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid_shift();
    test_fast();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
